// File: rtl/moving_average_peak_detector_pkg.sv
// Shared types and constants for the moving-average peak detector.
package moving_average_peak_detector_pkg;

  localparam int SIZE_DATA      = 16;
  localparam int SIZE_TIMESTAMP = 32;
  localparam int SIZE_HOLDOFF   = 8;
  localparam int SIZE_WIDTH     = 16;

  typedef enum logic [1:0] {
    PD_IDLE    = 2'd0,
    PD_TRACK   = 2'd1,
    PD_HOLDOFF = 2'd2
  } peak_state_t;

  // One detected pulse: maximum, timestamp of its first occurrence, width in samples.
  typedef struct packed {
    logic signed [SIZE_DATA-1:0]      data;
    logic        [SIZE_TIMESTAMP-1:0] timestamp;
    logic        [SIZE_WIDTH-1:0]     width;
  } peak_result_t;

  // Width counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [SIZE_WIDTH-1:0] sat_inc_width(input logic [SIZE_WIDTH-1:0] w);
    logic [SIZE_WIDTH-1:0] r;
    if (w == {SIZE_WIDTH{1'b1}}) begin
      r = w;
    end else begin
      r = w + {{(SIZE_WIDTH-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/moving_average_peak_detector_result_reg.sv
// Single-entry result holding register with valid/ready handshake.
// A new result is only accepted when the slot is empty or being emptied in
// the same cycle; otherwise it is dropped and the sticky overflow flag is set.
module peak_result_reg
  import moving_average_peak_detector_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  peak_result_t load_result,
  input  logic         ready,
  input  logic         clear_overflow,
  output logic         valid,
  output peak_result_t result,
  output logic         overflow
);

  logic         accept_s;
  logic         valid_r;
  peak_result_t result_r;
  logic         overflow_r;

  assign accept_s = (~valid_r) | ready;

  // Result slot: load on accepted emit, release on handshake, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r  <= 1'b0;
      result_r <= '0;
    end else if (load && accept_s) begin
      valid_r  <= 1'b1;
      result_r <= load_result;
    end else if (valid_r && ready) begin
      valid_r  <= 1'b0;
    end
  end

  // Sticky overflow: a drop sets it and wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (load && !accept_s) begin
      overflow_r <= 1'b1;
    end else if (clear_overflow) begin
      overflow_r <= 1'b0;
    end
  end

  assign valid    = valid_r;
  assign result   = result_r;
  assign overflow = overflow_r;

endmodule

// File: rtl/moving_average_peak_detector.sv
// Pulse detector with hysteresis and hold-off on a smoothed sample stream.
// Tracks the maximum of each pulse, its timestamp and width, and hands the
// result to a single-entry valid/ready output register.
module moving_average_peak_detector
  import moving_average_peak_detector_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic signed [SIZE_DATA-1:0]      input_data,
  input  logic                             input_valid,
  input  logic signed [SIZE_DATA-1:0]      threshold_high,
  input  logic signed [SIZE_DATA-1:0]      threshold_low,
  input  logic        [SIZE_HOLDOFF-1:0]   holdoff,
  output logic                             peak_valid,
  input  logic                             peak_ready,
  output logic signed [SIZE_DATA-1:0]      peak_data,
  output logic        [SIZE_TIMESTAMP-1:0] peak_time,
  output logic        [SIZE_WIDTH-1:0]     peak_width,
  output logic                             overflow,
  input  logic                             clear_overflow
);

  peak_state_t                      state_r,   state_next;
  logic signed [SIZE_DATA-1:0]      max_r,     max_next;
  logic        [SIZE_TIMESTAMP-1:0] ts_r,      ts_next;
  logic        [SIZE_WIDTH-1:0]     width_r,   width_next;
  logic        [SIZE_HOLDOFF-1:0]   hold_r,    hold_next;
  logic        [SIZE_TIMESTAMP-1:0] sample_count_r;
  logic                             emit_s;
  peak_result_t                     emit_result_s;
  peak_result_t                     out_result_s;

  // State register for the detection FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= PD_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Tracker and hold-off registers; reset discards any pulse in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_r   <= '0;
      ts_r    <= '0;
      width_r <= '0;
      hold_r  <= '0;
    end else begin
      max_r   <= max_next;
      ts_r    <= ts_next;
      width_r <= width_next;
      hold_r  <= hold_next;
    end
  end

  // Free-running sample counter, advanced by every valid sample in any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_count_r <= '0;
    end else if (input_valid) begin
      sample_count_r <= sample_count_r + 32'd1;
    end
  end

  // Next-state and tracker update; nothing moves without a valid sample.
  always_comb begin
    state_next = state_r;
    max_next   = max_r;
    ts_next    = ts_r;
    width_next = width_r;
    hold_next  = hold_r;
    emit_s     = 1'b0;
    if (input_valid) begin
      case (state_r)
        PD_IDLE: begin
          if (input_data > threshold_high) begin
            state_next = PD_TRACK;
            max_next   = input_data;
            ts_next    = sample_count_r;
            width_next = 16'd1;
          end else begin
            state_next = PD_IDLE;
          end
        end
        PD_TRACK: begin
          if (input_data >= threshold_low) begin
            width_next = sat_inc_width(width_r);
            if (input_data > max_r) begin
              max_next = input_data;
              ts_next  = sample_count_r;
            end else begin
              max_next = max_r;
            end
          end else begin
            // Terminating sample: it is not part of the pulse width.
            emit_s = 1'b1;
            if (holdoff == 8'd0) begin
              state_next = PD_IDLE;
            end else begin
              state_next = PD_HOLDOFF;
              hold_next  = holdoff;
            end
          end
        end
        PD_HOLDOFF: begin
          // The sample taking the counter to zero is still ignored.
          if (hold_r <= 8'd1) begin
            hold_next  = 8'd0;
            state_next = PD_IDLE;
          end else begin
            hold_next  = hold_r - 8'd1;
            state_next = PD_HOLDOFF;
          end
        end
        default: begin
          state_next = PD_IDLE;
        end
      endcase
    end else begin
      state_next = state_r;
    end
  end

  assign emit_result_s.data      = max_r;
  assign emit_result_s.timestamp = ts_r;
  assign emit_result_s.width     = width_r;

  peak_result_reg u_result_reg (
    .clk            (clk),
    .reset          (reset),
    .load           (emit_s),
    .load_result    (emit_result_s),
    .ready          (peak_ready),
    .clear_overflow (clear_overflow),
    .valid          (peak_valid),
    .result         (out_result_s),
    .overflow       (overflow)
  );

  assign peak_data  = out_result_s.data;
  assign peak_time  = out_result_s.timestamp;
  assign peak_width = out_result_s.width;

endmodule

// File: tb/tb_moving_average_peak_detector.sv
// Scoreboard bench for the moving-average peak detector: a pulse-list reference
// model predicts results, a negedge monitor compares whatever the DUT presents.
module tb_moving_average_peak_detector;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] input_data;
  logic               input_valid;
  logic signed [15:0] threshold_high;
  logic signed [15:0] threshold_low;
  logic        [7:0]  holdoff;
  logic               peak_valid;
  logic               peak_ready;
  logic signed [15:0] peak_data;
  logic        [31:0] peak_time;
  logic        [15:0] peak_width;
  logic               overflow;
  logic               clear_overflow;

  moving_average_peak_detector dut (
    .clk            (clk),
    .reset          (reset),
    .input_data     (input_data),
    .input_valid    (input_valid),
    .threshold_high (threshold_high),
    .threshold_low  (threshold_low),
    .holdoff        (holdoff),
    .peak_valid     (peak_valid),
    .peak_ready     (peak_ready),
    .peak_data      (peak_data),
    .peak_time      (peak_time),
    .peak_width     (peak_width),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint data;
    longint ts;
    longint width;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // reference model state: the pulse is kept as a plain list of samples
  bit     m_in_pulse;
  longint m_samp[$];
  longint m_ts[$];
  int     m_hold;
  longint m_count;
  bit     exp_valid;
  bit     exp_overflow;

  // last result taken by the monitor
  longint rx_data, rx_time, rx_width;
  int     rx_count = 0;

  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_pulse = 1'b0;
    m_samp.delete();
    m_ts.delete();
    m_hold = 0;
    m_count = 0;
    exp_valid = 1'b0;
    exp_overflow = 1'b0;
    exp_q.delete();
  endtask

  // One valid sample through the pulse/hysteresis/hold-off rules.
  task automatic model_step(input longint d, output bit emit, output exp_t r);
    longint th_h, th_l;
    int best;
    th_h = threshold_high;
    th_l = threshold_low;
    emit = 1'b0;
    r = '{0, 0, 0};
    if (m_hold > 0) begin
      m_hold--;
    end else if (!m_in_pulse) begin
      if (d > th_h) begin
        m_in_pulse = 1'b1;
        m_samp.push_back(d);
        m_ts.push_back(m_count);
      end
    end else if (d >= th_l) begin
      m_samp.push_back(d);
      m_ts.push_back(m_count);
    end else begin
      best = 0;
      for (int i = 1; i < m_samp.size(); i++)
        if (m_samp[i] > m_samp[best]) best = i;
      r.data  = m_samp[best];
      r.ts    = m_ts[best];
      r.width = (m_samp.size() > 65535) ? 65535 : m_samp.size();
      emit = 1'b1;
      m_in_pulse = 1'b0;
      m_samp.delete();
      m_ts.delete();
      m_hold = holdoff;
    end
    m_count = (m_count + 1) % 64'h1_0000_0000;
  endtask

  // Drive one clock cycle (called at posedge+1) and advance the expected state.
  task automatic drive_cycle(input bit v, input longint d, input bit rdy, input bit clr);
    bit   emit;
    bit   accept;
    exp_t r;
    input_valid    = v;
    input_data     = d[15:0];
    peak_ready     = rdy;
    clear_overflow = clr;
    emit = 1'b0;
    if (v) model_step(d, emit, r);
    accept = !exp_valid || rdy;
    @(posedge clk);
    if (emit && accept) begin
      exp_q.push_back(r);
      exp_valid = 1'b1;
    end else if (exp_valid && rdy) begin
      exp_valid = 1'b0;
    end
    if (emit && !accept) exp_overflow = 1'b1;
    else if (clr) exp_overflow = 1'b0;
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_peak_valid", peak_valid, 0);
    check("rst_peak_data", peak_data, 0);
    check("rst_peak_time", peak_time, 0);
    check("rst_peak_width", peak_width, 0);
    check("rst_overflow", overflow, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    input_valid = 1'b0;
    peak_ready = 1'b1;
    clear_overflow = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;
  endtask

  task automatic feed(input longint s[$]);
    foreach (s[i]) drive_cycle(1'b1, s[i], 1'b1, 1'b0);
  endtask

  task automatic feed_gaps(input longint s[$]);
    foreach (s[i]) begin
      drive_cycle(1'b1, s[i], 1'b1, 1'b0);
      repeat ($urandom_range(0, 3)) drive_cycle(1'b0, 0, 1'b1, 1'b0);
    end
  endtask

  // Bounded wait for the monitor to take a result, then check it against constants.
  task automatic expect_rx(input string name, input int start, input longint d,
                           input longint t, input longint w);
    for (int i = 0; i < 20 && rx_count == start; i++) drive_cycle(1'b0, 0, 1'b1, 1'b0);
    if (rx_count == start) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: got no result expected one", name);
    end else begin
      check({name, "_data"}, rx_data, d);
      check({name, "_time"}, rx_time, t);
      check({name, "_width"}, rx_width, w);
    end
  endtask

  // Monitor: compare handshake state every cycle and pop results as they are taken.
  always @(negedge clk) begin
    if (!reset) begin
      check("peak_valid", peak_valid, exp_valid);
      check("overflow", overflow, exp_overflow);
      if (peak_valid) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_result: got data %0d expected none", peak_data);
        end else begin
          check("peak_data", peak_data, exp_q[0].data);
          check("peak_time", peak_time, exp_q[0].ts);
          check("peak_width", peak_width, exp_q[0].width);
          if (peak_ready) begin
            rx_data  = peak_data;
            rx_time  = peak_time;
            rx_width = peak_width;
            void'(exp_q.pop_front());
            rx_count++;
          end
        end
      end
    end
  end

  initial begin
    int start;
    reset = 1'b1;
    input_valid = 1'b0;
    input_data = '0;
    peak_ready = 1'b1;
    clear_overflow = 1'b0;
    threshold_high = 16'sd100;
    threshold_low  = 16'sd50;
    holdoff = 8'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;

    // 1: basic pulse
    start = rx_count;
    feed('{0, 120, 150, 130, 40});
    check("t1_valid_after_last", peak_valid, 1);
    expect_rx("t1", start, 150, 2, 3);

    // 2: hysteresis with input gaps
    do_reset();
    start = rx_count;
    feed_gaps('{120, 80, 60, 200, 40});
    expect_rx("t2", start, 200, 3, 4);

    // 3: backpressure, drop and overflow handling
    do_reset();
    start = rx_count;
    foreach (m_samp[i]) ;
    drive_cycle(1'b1, 120, 1'b0, 1'b0);
    drive_cycle(1'b1, 40, 1'b0, 1'b0);
    drive_cycle(1'b1, 130, 1'b0, 1'b0);
    drive_cycle(1'b1, 40, 1'b0, 1'b0);
    repeat (2) drive_cycle(1'b0, 0, 1'b0, 1'b0);
    check("t3_overflow_set", overflow, 1);
    check("t3_held_data", peak_data, 120);
    drive_cycle(1'b0, 0, 1'b0, 1'b1);
    check("t3_overflow_cleared", overflow, 0);
    drive_cycle(1'b0, 0, 1'b1, 1'b0);
    check("t3_valid_fell", peak_valid, 0);
    check("t3_rx_data", rx_data, 120);
    check("t3_rx_count", rx_count - start, 1);

    // 4: hold-off ignores samples after a pulse
    do_reset();
    holdoff = 8'd3;
    feed('{120, 40});
    start = rx_count + 1;
    feed('{500, 500, 500, 500, 40});
    expect_rx("t4", start, 500, 5, 1);
    holdoff = 8'd0;

    // 5: signed thresholds
    do_reset();
    threshold_high = -16'sd10;
    threshold_low  = -16'sd20;
    start = rx_count;
    feed('{-5, -15, -25});
    expect_rx("t5", start, -5, 0, 2);
    threshold_high = 16'sd100;
    threshold_low  = 16'sd50;

    // 6: reset in the middle of a pulse
    do_reset();
    feed('{0, 120, 150});
    do_reset();
    start = rx_count;
    feed('{0, 120, 40});
    expect_rx("t6", start, 120, 1, 1);
    check("t6_overflow", overflow, 0);

    // random traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        threshold_high = 16'($signed($urandom_range(0, 300)) - 150);
        if ($urandom_range(0, 5) == 0)
          threshold_low = threshold_high + 16'sd20;
        else
          threshold_low = threshold_high - 16'($urandom_range(0, 100));
      end
      holdoff = 8'($urandom_range(0, 3));
      drive_cycle(($urandom_range(0, 3) != 0),
                  longint'($urandom_range(0, 600)) - 300,
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 19) == 0));
    end
    repeat (5) drive_cycle(1'b0, 0, 1'b1, 1'b0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
